// File: rtl/inst_enc_pkg.sv
// rtl/inst_enc_pkg.sv - instruction classes and MIPS opcodes for the instruction encoder
package inst_enc_pkg;

    typedef enum logic [2:0] {
        KIND_R   = 3'd0,
        KIND_LW  = 3'd1,
        KIND_SW  = 3'd2,
        KIND_BEQ = 3'd3,
        KIND_J   = 3'd4
    } kind_e;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

endpackage

// File: rtl/inst_encoder_if.sv
// rtl/inst_encoder_if.sv - field handshake and instruction-memory write port of the encoder
interface inst_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/inst_pack.sv
// rtl/inst_pack.sv - combinational field packer; kind 4 is legal only with ENC_JUMP_EN
module inst_pack
    import inst_enc_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (kind_e'(kind))
            KIND_R:   word = {OP_R, rs, rt, rd, 5'b00000, funct};
            KIND_LW:  word = {OP_LW, rs, rt, imm};
            KIND_SW:  word = {OP_SW, rs, rt, imm};
            KIND_BEQ: word = {OP_BEQ, rs, rt, imm};
            KIND_J: begin
                // The word is always formed; only legality depends on the build.
                word = {OP_J, target};
`ifdef ENC_JUMP_EN
                legal = 1'b1;
`else
                legal = 1'b0;
`endif
            end
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - sequential instruction encoder/loader; J support via ENC_JUMP_EN
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    inst_encoder_if.slave   bus,
    output logic [ADDR_W:0] count,
    output logic            full,
    output logic            err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       word;
    logic              legal;

    inst_pack u_pack (
        .kind   (bus.in_kind),
        .rs     (bus.in_rs),
        .rt     (bus.in_rt),
        .rd     (bus.in_rd),
        .funct  (bus.in_funct),
        .imm    (bus.in_imm),
        .target (bus.in_target),
        .word   (word),
        .legal  (legal)
    );

    assign bus.in_ready = (state == S_IDLE) && !start;
    assign full         = (state == S_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            wr_addr        <= '0;
            count          <= '0;
            err            <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            err         <= 1'b0;
            // A write already on the port this cycle still completes; it just is not counted.
            if (start) begin
                state   <= S_IDLE;
                wr_addr <= '0;
                count   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.in_valid) begin
                            if (legal) begin
                                state          <= S_WRITE;
                                bus.imem_we    <= 1'b1;
                                bus.imem_addr  <= wr_addr;
                                bus.imem_wdata <= word;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    S_WRITE: begin
                        wr_addr <= wr_addr + 1'b1;
                        count   <= count + 1'b1;
                        state   <= (wr_addr == LAST_ADDR) ? S_FULL : S_IDLE;
                    end
                    S_FULL:  state <= S_FULL;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Sequential instruction encoder and loader, the write-side counterpart of the single-cycle CPU's opcode decoder. It accepts instruction fields over a valid/ready handshake and packs them into 32-bit MIPS words for the five supported instruction classes: R-type, LW, SW, BEQ and J. It writes each word into instruction memory at an auto-incrementing address. It sits between the program-load path (bench or debug host) and the instruction-memory write port.

## Interface
Parameters:
- ADDR_W, 6, instruction-memory word-address width; capacity 2^ADDR_W words.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; restarts loading at word address 0.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept this cycle.
- in_kind  in  3  instruction class: 0=R, 1=LW, 2=SW, 3=BEQ, 4=J; 5–7 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_funct  in  6  R-type function field.
- in_imm  in  16  immediate/offset for LW, SW, BEQ.
- in_target  in  26  J target field.
- imem_we  out  1  instruction-memory write enable, one-cycle pulse.
- imem_addr  out  ADDR_W  word address of the current write.
- imem_wdata  out  32  encoded instruction word.
- count  out  ADDR_W+1  number of words written since reset/start.
- full  out  1  memory filled; no further accepts until start.
- err  out  1  one-cycle pulse when an illegal kind is accepted.

## Operation
- Encodings:
  - R: {000000, rs, rt, rd, 00000, funct}.
  - LW: {100011, rs, rt, imm}.
  - SW: {101011, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}.
  - J: {000010, target}.
- Unused input fields are ignored.
- FSM states:
  - IDLE: in_ready = ~start.
  - WRITE: one cycle; imem_we=1, then addr and count increment.
  - FULL: in_ready=0.
- Transitions:
  - IDLE→WRITE on a handshake with a legal kind.
  - Illegal kind: handshake completes, err pulses next cycle, no write, no address advance; state stays IDLE.
  - WRITE→IDLE normally.
  - WRITE→FULL when the written address was 2^ADDR_W−1. Address wraps to 0; count = 2^ADDR_W; full=1.
- start in any state: next cycle state=IDLE, address=0, count=0, full=0.
  - start coincident with a WRITE cycle: the write already presented that cycle completes at its address and is not counted.
  - start has priority over a handshake in the same cycle; in_ready is low that cycle.
- imem_wdata and imem_addr are registered and held stable while imem_we is high. Between writes they hold their last values.

## Timing
- Reset values:
  - state IDLE, in_ready=1.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - count=0, full=0, err=0.
- Latency: handshake in cycle N → imem_we high in cycle N+1 → in_ready high again in N+2.
- Throughput: one word per 2 cycles.
- err is high for exactly the cycle after an illegal handshake.
- Reset asserted mid-WRITE: imem_we drops immediately (asynchronous). The write is lost and not counted.

## Configuration
- ENC_JUMP_EN defined: kind 4 encodes as J.
- ENC_JUMP_EN undefined: kind 4 is illegal (err pulse, no write). in_target is unused.

## Structure
- Package inst_enc_pkg holds:
  - kind enum (KIND_R, KIND_LW, KIND_SW, KIND_BEQ, KIND_J).
  - opcode constants OP_R=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_J=000010.
- One combinational sub-module, inst_pack: fields + kind → 32-bit word + legal flag. FSM, address counter and output registers stay in inst_encoder.

## Test plan
- Reset, then R kind, rs=1, rt=2, rd=3, funct=100000 → cycle N+1: imem_we=1, addr=0, wdata=0x00221820; count=1.
- LW rs=0, rt=8, imm=0x0004 then SW same fields → wdata 0x8C080004 at addr 0, then 0xAC080004 at addr 1; in_ready low for one cycle after each handshake.
- BEQ rs=1, rt=2, imm=0xFFFF → 0x1022FFFF; J target=0x0000010 with ENC_JUMP_EN → 0x08000010. Without the macro, the J request → err pulse, no imem_we, count unchanged.
- Illegal kind 6 → err high one cycle, imem_we stays 0, next accept writes to the unchanged address.
- ADDR_W=2, four legal writes → full=1 after the 4th, count=4, in_ready=0. A fifth in_valid is held off. start → full=0, count=0, next write lands at addr 0.
- rst_n low during the WRITE cycle → all outputs at reset values immediately. After release, in_ready=1 and count=0.
